// File: rtl/route_compute_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC definitions: flit-type codes, output-port
//               encodings and the route-compute FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // Flit type lives in the two MSBs of every flit
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  // Router output-port encodings
  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_EAST  = 3'd2;
  localparam logic [2:0] PORT_SOUTH = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  // Route-lock FSM: IDLE waits for a head, PKT holds the locked route
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/route_compute_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : route_compute_unit_if
// Description : Valid/ready flit link into the route-compute stage and the
//               routed flit link out of it toward the VC buffers.
//               master = link/buffer side, slave = route_compute_unit side.
// Revision    : 1.0 - initial release
// ============================================================================
interface route_compute_unit_if #(
  parameter int FLIT_W = 8
);
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_port;

  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_valid, out_port
  );

  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_valid, out_port
  );
endinterface
`default_nettype wire

// File: rtl/route_compute_unit_xy_route_calc.sv
`default_nettype none
// ============================================================================
// Module      : xy_route_calc
// Description : Combinational dimension-ordered (X first, then Y) output
//               port selection from destination coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int X_W  = 3,
  parameter int Y_W  = 3,
  parameter int MY_X = 0,
  parameter int MY_Y = 0
) (
  input  wire logic [X_W-1:0] i_dest_x,
  input  wire logic [Y_W-1:0] i_dest_y,
  output logic      [2:0]     o_port
);

  localparam logic [X_W-1:0] c_MY_X = X_W'(MY_X);
  localparam logic [Y_W-1:0] c_MY_Y = Y_W'(MY_Y);

  // Resolve X offset first; Y is only considered once X matches
  always_comb begin
    o_port = PORT_LOCAL;
    if (i_dest_x > c_MY_X)       o_port = PORT_EAST;
    else if (i_dest_x < c_MY_X)  o_port = PORT_WEST;
    else if (i_dest_y > c_MY_Y)  o_port = PORT_NORTH;
    else if (i_dest_y < c_MY_Y)  o_port = PORT_SOUTH;
    else                         o_port = PORT_LOCAL;
  end

endmodule
`default_nettype wire

// File: rtl/route_compute_unit.sv
`default_nettype none
// ============================================================================
// Module      : route_compute_unit
// Description : Per-input route computation stage. Computes the XY output
//               port on head/single flits, locks it for the packet until the
//               tail, and presents flits through a one-entry output register.
//               Optional macro RCU_PROTO_CHECK_EN enables the sticky err flag
//               for out-of-sequence flit types.
// Revision    : 1.0 - initial release
// ============================================================================
module route_compute_unit
  import noc_pkg::*;
#(
  parameter int FLIT_W = 8,
  parameter int X_W    = 3,
  parameter int Y_W    = 3,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  route_compute_unit_if.slave bus,
  output logic               busy,
  output logic               err
);

  logic [1:0]        w_type;
  logic [X_W-1:0]    w_dest_x;
  logic [Y_W-1:0]    w_dest_y;
  logic [2:0]        w_calc_port;
  logic              w_in_ready;
  logic              w_xfer;
  logic              w_load;
  logic              w_store_route;
  logic [2:0]        w_sel_port;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_route_q;
  logic [FLIT_W-1:0] r_out_flit;
  logic [2:0]        r_out_port;
  logic              r_out_valid;

  assign w_type   = bus.in_flit[FLIT_W-1 -: 2];
  assign w_dest_x = bus.in_flit[X_W+Y_W-1 : Y_W];
  assign w_dest_y = bus.in_flit[Y_W-1 : 0];

  xy_route_calc #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .MY_X (MY_X),
    .MY_Y (MY_Y)
  ) u_xy_route_calc (
    .i_dest_x (w_dest_x),
    .i_dest_y (w_dest_y),
    .o_port   (w_calc_port)
  );

  // Accept whenever the output register is empty or draining this cycle
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_xfer     = bus.in_valid && w_in_ready;

  // FSM state register; reset aborts any packet in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: only a completed transfer can move the FSM
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      case (r_state)
        ST_IDLE: if (w_type == FLIT_HEAD) w_state_nxt = ST_PKT;
        ST_PKT:  if (w_type == FLIT_TAIL) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: what to load into the output register and with which port
  always_comb begin
    w_load        = 1'b0;
    w_store_route = 1'b0;
    w_sel_port    = r_route_q;
    busy          = (r_state == ST_PKT);
    if (w_xfer) begin
      case (r_state)
        ST_IDLE: begin
          // Orphan body/tail flits are consumed but never forwarded
          if (w_type == FLIT_HEAD || w_type == FLIT_SINGLE) begin
            w_load        = 1'b1;
            w_sel_port    = w_calc_port;
            w_store_route = (w_type == FLIT_HEAD);
          end
        end
        ST_PKT: begin
          // Any flit inside a packet follows the locked route, even a stray head
          w_load     = 1'b1;
          w_sel_port = r_route_q;
        end
        default: ;
      endcase
    end
  end

  // Locked route and one-entry output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_route_q   <= PORT_LOCAL;
      r_out_flit  <= '0;
      r_out_port  <= PORT_LOCAL;
      r_out_valid <= 1'b0;
    end else begin
      if (w_store_route) r_route_q <= w_calc_port;
      if (w_load) begin
        r_out_flit  <= bus.in_flit;
        r_out_port  <= w_sel_port;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef RCU_PROTO_CHECK_EN
  logic w_proto_err;
  logic r_err;

  assign w_proto_err = w_xfer &&
    (((r_state == ST_IDLE) && (w_type == FLIT_BODY || w_type == FLIT_TAIL)) ||
     ((r_state == ST_PKT)  && (w_type == FLIT_HEAD || w_type == FLIT_SINGLE)));

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_err <= 1'b0;
    else if (w_proto_err) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_flit  = r_out_flit;
  assign bus.out_port  = r_out_port;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_route_compute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_route_compute_unit
// Description : Directed self-checking bench for route_compute_unit at
//               router coordinate (2,2). Honors RCU_PROTO_CHECK_EN for err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_route_compute_unit;

  localparam int FLIT_W = 8;
  localparam int X_W    = 3;
  localparam int Y_W    = 3;

`ifdef RCU_PROTO_CHECK_EN
  localparam logic c_ERR_ON = 1'b1;
`else
  localparam logic c_ERR_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  logic busy;
  logic err;
  int   checks;
  int   failures;
  logic [7:0] r_exp_flit;

  route_compute_unit_if #(.FLIT_W(FLIT_W)) bus ();

  route_compute_unit #(
    .FLIT_W (FLIT_W),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .MY_X   (2),
    .MY_Y   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input logic [1:0] t, input int x, input int y);
    logic [2:0] xx;
    logic [2:0] yy;
    xx = x[2:0];
    yy = y[2:0];
    return {t, xx, yy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.in_flit   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_flit",  {24'd0, bus.out_flit},  32'd0);
    chk("rst_out_port",  {29'd0, bus.out_port},  32'd0);
    chk("rst_busy",      {31'd0, busy},          32'd0);
    chk("rst_err",       {31'd0, err},           32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    reset = 1'b1;
    step();

    // SINGLE to (3,1): EAST, no lock
    bus.in_flit  = mk(2'b11, 3, 1);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("single_port",  {29'd0, bus.out_port},  32'd2);
    chk("single_flit",  {24'd0, bus.out_flit},  {24'd0, mk(2'b11, 3, 1)});
    chk("single_busy",  {31'd0, busy},          32'd0);
    step();
    chk("single_drain", {31'd0, bus.out_valid}, 32'd0);

    // HEAD to (2,0) + 3 BODY + TAIL back to back: all SOUTH
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      bus.in_flit = mk(2'b01, 2, 0);
      else if (i == 4) bus.in_flit = mk(2'b10, 7, i);
      else             bus.in_flit = mk(2'b00, 5, i);
      r_exp_flit   = bus.in_flit;
      bus.in_valid = 1'b1;
      step();
      chk("pkt_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("pkt_port",  {29'd0, bus.out_port},  32'd3);
      chk("pkt_flit",  {24'd0, bus.out_flit},  {24'd0, r_exp_flit});
      chk("pkt_busy",  {31'd0, busy},          (i == 4) ? 32'd0 : 32'd1);
    end
    bus.in_valid = 1'b0;
    step();

    // HEAD to (2,2) under backpressure: LOCAL, stable, in_ready low
    bus.out_ready = 1'b0;
    bus.in_flit   = mk(2'b01, 2, 2);
    bus.in_valid  = 1'b1;
    step();
    chk("bp_head_port", {29'd0, bus.out_port}, 32'd0);
    chk("bp_head_busy", {31'd0, busy},         32'd1);
    bus.in_flit = mk(2'b00, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", {31'd0, bus.in_ready},  32'd0);
      chk("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
      chk("bp_flit",     {24'd0, bus.out_flit},  {24'd0, mk(2'b01, 2, 2)});
      chk("bp_port",     {29'd0, bus.out_port},  32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("bp_next_flit",  {24'd0, bus.out_flit},  {24'd0, mk(2'b00, 1, 1)});
    chk("bp_next_port",  {29'd0, bus.out_port},  32'd0);
    chk("bp_next_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_flit = mk(2'b10, 0, 0);
    step();
    chk("bp_tail_busy", {31'd0, busy}, 32'd0);
    bus.in_valid = 1'b0;
    step();

    // Orphan BODY in IDLE: dropped, err only with protocol checking
    bus.in_flit  = mk(2'b00, 6, 6);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("orphan_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("orphan_busy",  {31'd0, busy},          32'd0);
    chk("orphan_err",   {31'd0, err},           {31'd0, c_ERR_ON});
    step();

    // HEAD to (0,2) WEST, then a stray HEAD to (4,2) keeps WEST
    bus.in_flit  = mk(2'b01, 0, 2);
    bus.in_valid = 1'b1;
    step();
    chk("west_port", {29'd0, bus.out_port}, 32'd4);
    chk("west_busy", {31'd0, busy},         32'd1);
    bus.in_flit = mk(2'b01, 4, 2);
    step();
    bus.in_valid = 1'b0;
    chk("stray_port",  {29'd0, bus.out_port}, 32'd4);
    chk("stray_flit",  {24'd0, bus.out_flit}, {24'd0, mk(2'b01, 4, 2)});
    chk("stray_busy",  {31'd0, busy},         32'd1);
    chk("stray_err",   {31'd0, err},          {31'd0, c_ERR_ON});

    // Reset mid-packet with a flit held: cleared asynchronously
    bus.out_ready = 1'b0;
    step();
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_busy",  {31'd0, busy},          32'd0);
    chk("midrst_err",   {31'd0, err},           32'd0);
    step();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();

    // SINGLE to (2,3): NORTH
    bus.in_flit  = mk(2'b11, 2, 3);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("north_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("north_port",  {29'd0, bus.out_port},  32'd1);
    chk("north_busy",  {31'd0, busy},          32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/route_compute_unit.md
# route_compute_unit

Parametrised per-input route computation stage for the mesh NoC: it inspects head flits, computes the dimension-ordered (XY) output port from the destination coordinates, and locks that port for the rest of the packet until the tail flit. It sits between an input port's link and the per-direction VC buffers. It replaces the fixed 8-bit, 4-direction router with configurable flit/coordinate widths, a local port, and valid/ready flow control. It has a one-entry registered output stage.

## Interface
Parameters:
- FLIT_W, 8, total flit width; must be ≥ 2 + X_W + Y_W
- X_W, 3, destination X field width
- Y_W, 3, destination Y field width
- MY_X, 0, this router's X coordinate (< 2**X_W)
- MY_Y, 0, this router's Y coordinate (< 2**Y_W)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- in_flit  in  FLIT_W  incoming flit
- in_valid  in  1  in_flit is valid
- in_ready  out  1  stage can accept a flit this cycle
- out_flit  out  FLIT_W  registered flit toward the VC buffers
- out_valid  out  1  out_flit/out_port valid
- out_ready  in  1  downstream accepts out_flit
- out_port  out  3  selected output port: 0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST
- busy  out  1  a packet's route is locked (state PKT)
- err  out  1  sticky protocol error (only with RCU_PROTO_CHECK_EN; tied 0 otherwise)

## Operation
- Flit type is in_flit[FLIT_W-1:FLIT_W-2]: 00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE (head+tail). The head/single destination fields are dest_x = in_flit[X_W+Y_W-1:Y_W] and dest_y = in_flit[Y_W-1:0].
- XY route, using unsigned compares at X_W/Y_W width:
  - dest_x > MY_X → EAST
  - dest_x < MY_X → WEST
  - otherwise, dest_y > MY_Y → NORTH
  - otherwise, dest_y < MY_Y → SOUTH
  - otherwise → LOCAL
- A transfer occurs when in_valid && in_ready. in_ready = !out_valid || out_ready. The stage is a pass-through pipeline register with no combinational in→out path except via out_ready.
- FSM states are IDLE and PKT. The reset state is IDLE.
  - IDLE + HEAD transfer: compute the route, store it in route_q, register the flit with that port, go to PKT.
  - IDLE + SINGLE transfer: compute the route, register the flit, stay in IDLE.
  - IDLE + BODY/TAIL transfer: the flit is consumed and discarded (out_valid does not rise), stay in IDLE.
  - PKT + BODY transfer: forward the flit with out_port = route_q.
  - PKT + TAIL transfer: forward with route_q, go to IDLE.
  - PKT + HEAD/SINGLE transfer: forward with route_q as a body flit, stay in PKT. The route is not recomputed.
- busy = (state == PKT).
- Reset values: out_valid 0, out_flit 0, out_port 0, busy 0, err 0, route_q 0. in_ready is 1 out of reset.
- Reset asserted mid-packet aborts the packet: go to IDLE and drop any registered flit.

## Timing
- Latency is 1 cycle: a flit accepted at edge N appears on out_flit/out_port after edge N, and out_valid stays high until out_ready.
- Throughput is 1 flit/cycle while out_ready is held high.
- Backpressure: while out_valid && !out_ready, the outputs hold stable and in_ready = 0.
- If out_ready and in_valid occur in the same cycle with out_valid = 1, the old flit leaves and the new one loads on the same edge.
- The FSM advances only on a transfer. An idle in_valid never changes state.

## Configuration
- RCU_PROTO_CHECK_EN defined:
  - err goes high the cycle after a BODY/TAIL arrives in IDLE, or a HEAD/SINGLE arrives in PKT.
  - err stays high until reset.
- Not defined: err is tied to 0, with no extra logic. The datapath behaviour is identical either way.

## Structure
- Package noc_pkg holds:
  - the flit-type constants (FLIT_BODY/HEAD/TAIL/SINGLE)
  - the port encodings (PORT_LOCAL..PORT_WEST)
  - the FSM state typedef
- Sub-module xy_route_calc is purely combinational (dest_x, dest_y → port) and is parametrised by X_W, Y_W, MY_X, MY_Y. It is reused by future adaptive variants.

## Test plan
- MY_X=2, MY_Y=2; SINGLE to (3,1) → out_port=2 (EAST) one cycle later, busy stays 0.
- HEAD to (2,0), then 3 BODY, then TAIL, out_ready=1 → all 5 flits carry out_port=3 (SOUTH); busy is 1 from the HEAD transfer until the TAIL transfer.
- HEAD to (2,2), hold out_ready=0 for 4 cycles → in_ready=0, out_flit/out_port=0 (LOCAL) stable; release → next flit loads on the same edge.
- BODY in IDLE → no out_valid pulse; err=1 only with RCU_PROTO_CHECK_EN.
- HEAD to (0,2) (WEST), then a HEAD to (4,2) mid-packet → the second head forwards with out_port=4; err=1 with the macro.
- Assert reset during PKT with out_valid=1 → out_valid=0 and busy=0 immediately; a following SINGLE to (2,3) routes NORTH.
